pacman_motion: RTL and testbench

- Produces the maze-relative Pac-Man centre coordinates (pacman_X, pacman_Y) consumed by the pellet tracker and the sprite renderer.
- Moves one pixel per movement tick, driven by the vertical-sync frame clock.
- Accepts WASD keycodes with a buffered "desired direction" (pre-turn) and enforces maze walls via a tile walkability lookup.
- Turns only at tile centres; reverses immediately at any position.

---
 rtl/pacman_pkg.sv | 93 +++++++++
 rtl/pacman_motion_if.sv | 22 ++
 rtl/pacman_motion_maze.sv | 25 ++
 rtl/pacman_motion.sv | 166 ++++++++++++++++
 tb/tb_pacman_motion.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pacman_pkg.sv
// Shared types, keycodes and the static maze walkability map for Pac-Man motion.
// Row 0 is the top of the maze and column 0 is its left edge.
package pacman_pkg;

    localparam int TILE_SIZE = 8;
    localparam int MAZE_W    = 28;
    localparam int MAZE_H    = 36;

    typedef enum logic [1:0] {
        RIGHT = 2'd0,
        LEFT  = 2'd1,
        UP    = 2'd2,
        DOWN  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_DECIDE = 2'd1,
        S_STEP   = 2'd2
    } motion_state_t;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_D = 8'h07;

    typedef struct packed {
        logic valid;
        dir_t dir;
    } key_cmd_t;

    // Ascending bit order, so each literal reads left to right exactly like the maze row.
    typedef logic [0:MAZE_W-1] maze_row_t;

    localparam maze_row_t MAZE_WALK [0:MAZE_H-1] = '{
        28'b0000000000000000000000000000,
        28'b0_111111111111_00_111111111111_0,
        28'b0_1_0000_1_00000_1_00_1_00000_1_0000_1_0,
        28'b0_1_0000_1_00000_1_00_1_00000_1_0000_1_0,
        28'b0_1_0000_1_00000_1_00_1_00000_1_0000_1_0,
        28'b0_1111111111111_1111111111111_0,
        28'b0_1_0000_1_00_1_00000000_1_00_1_0000_1_0,
        28'b0_1_0000_1_00_1_00000000_1_00_1_0000_1_0,
        28'b0_111111_00_1111_00_1111_00_111111_0,
        28'b000000_1_00000_1_00_1_00000_1_000000,
        28'b000000_1_00000_1_00_1_00000_1_000000,
        28'b000000_1_00_1111111111_00_1_000000,
        28'b000000_1_00_1_00000000_1_00_1_000000,
        28'b000000_1_00_1_00000000_1_00_1_000000,
        28'b1111111111_00000000_1111111111,
        28'b000000_1_00_1_00000000_1_00_1_000000,
        28'b000000_1_00_1_00000000_1_00_1_000000,
        28'b000000_1_00_1111111111_00_1_000000,
        28'b000000_1_00_1_00000000_1_00_1_000000,
        28'b000000_1_00_1_00000000_1_00_1_000000,
        28'b0_111111111111_00_111111111111_0,
        28'b0_1_0000_1_00000_1_00_1_00000_1_0000_1_0,
        28'b0_1_0000_1_00000_1_00_1_00000_1_0000_1_0,
        28'b0_111_00_11111111_11111111_00_111_0,
        28'b000_1_00_1_00_1_00000000_1_00_1_00_1_000,
        28'b000_1_00_1_00_1_00000000_1_00_1_00_1_000,
        28'b0_111111_00_1111_00_1111_00_111111_0,
        28'b0_1_0000000000_1_00_1_0000000000_1_0,
        28'b0_1_0000000000_1_00_1_0000000000_1_0,
        28'b0_1111111111111_1111111111111_0,
        28'b0000000000000000000000000000,
        28'b0000000000000000000000000000,
        28'b0000000000000000000000000000,
        28'b0000000000000000000000000000,
        28'b0000000000000000000000000000,
        28'b0000000000000000000000000000
    };

    // RIGHT/LEFT and UP/DOWN differ only in bit 0.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

    function automatic key_cmd_t decode_key(input logic [7:0] code);
        key_cmd_t cmd;
        cmd.valid = 1'b1;
        cmd.dir   = LEFT;
        case (code)
            KEY_W:   cmd.dir = UP;
            KEY_A:   cmd.dir = LEFT;
            KEY_S:   cmd.dir = DOWN;
            KEY_D:   cmd.dir = RIGHT;
            default: cmd.valid = 1'b0;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/pacman_motion_if.sv
// Control inputs and position outputs of the Pac-Man motion block.
interface pacman_motion_if;
    import pacman_pkg::*;

    logic       frame_clk;
    logic [7:0] keycode;
    logic       freeze;
    logic [9:0] pacman_X;
    logic [9:0] pacman_Y;
    dir_t       pacman_dir;
    logic       moving;

    modport master (
        output frame_clk, keycode, freeze,
        input  pacman_X, pacman_Y, pacman_dir, moving
    );

    modport slave (
        input  frame_clk, keycode, freeze,
        output pacman_X, pacman_Y, pacman_dir, moving
    );
endinterface

// File: rtl/pacman_motion_maze.sv
// Combinational maze walkability lookup; any tile outside the 28x36 map reads as wall.
module maze_walkable
    import pacman_pkg::*;
(
    input  logic [4:0] tile_col,
    input  logic [5:0] tile_row,
    output logic       walkable
);

    logic              col_ok;
    logic [MAZE_H-1:0] row_hit;

    assign col_ok = (tile_col < 5'(MAZE_W));

    // One-hot row decode ORed together; at most one row can match.
    genvar gi;
    generate
        for (gi = 0; gi < MAZE_H; gi++) begin : g_row
            assign row_hit[gi] = col_ok && (tile_row == 6'(gi)) && MAZE_WALK[gi][tile_col];
        end
    endgenerate

    assign walkable = |row_hit;

endmodule

// File: rtl/pacman_motion.sv
// Pac-Man centre position tracker: frame-tick paced, buffered turns at tile centres,
// immediate reversals, and wall blocking through a single shared maze lookup.
module pacman_motion
    import pacman_pkg::*;
#(
    parameter int START_TILE_X   = 13,
    parameter int START_TILE_Y   = 29,
    parameter int TICKS_PER_STEP = 1
) (
    input  logic     Clk,
    input  logic     Reset,
    pacman_motion_if.slave bus
);

    localparam logic [9:0] X_START  = 10'(START_TILE_X * TILE_SIZE + 4);
    localparam logic [9:0] Y_START  = 10'(START_TILE_Y * TILE_SIZE + 4);
    localparam logic [3:0] TPS_LAST = 4'(TICKS_PER_STEP - 1);

    logic          frame_clk_q_reg;
    logic          tick_pulse;
    logic [3:0]    tick_cnt_reg;
    logic          step_req_reg;

    motion_state_t state_reg, state_next;
    dir_t          pacman_dir_reg, pacman_dir_next;
    dir_t          desired_dir_reg;
    logic [9:0]    x_reg, x_next;
    logic [9:0]    y_reg, y_next;
    logic          moving_reg, moving_next;

    key_cmd_t      key_cmd;
    logic          at_centre;
    dir_t          probe_dir;
    logic [6:0]    tile_x, tile_y;
    logic [6:0]    nb_x, nb_y;
    logic          nb_in_range;
    logic          nb_walk_raw;
    logic          nb_walk;

    // Frame tick pacing: one step request every TICKS_PER_STEP rising edges of frame_clk.
    assign tick_pulse = bus.frame_clk & ~frame_clk_q_reg;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_clk_q_reg <= 1'b0;
            tick_cnt_reg    <= 4'd0;
            step_req_reg    <= 1'b0;
        end else begin
            frame_clk_q_reg <= bus.frame_clk;
            step_req_reg    <= 1'b0;
            if (tick_pulse) begin
                if (tick_cnt_reg == TPS_LAST) begin
                    tick_cnt_reg <= 4'd0;
                    step_req_reg <= 1'b1;
                end else begin
                    tick_cnt_reg <= tick_cnt_reg + 4'd1;
                end
            end
        end
    end

    // Keys are buffered at any time, even while frozen or mid-step.
    assign key_cmd = decode_key(bus.keycode);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            desired_dir_reg <= LEFT;
        end else if (key_cmd.valid) begin
            desired_dir_reg <= key_cmd.dir;
        end
    end

    assign at_centre = (x_reg[2:0] == 3'd4) && (y_reg[2:0] == 3'd4);

    // DECIDE probes the buffered direction, STEP probes the committed heading.
    assign probe_dir = (state_reg == S_DECIDE) ? desired_dir_reg : pacman_dir_reg;
    assign tile_x    = x_reg[9:3];
    assign tile_y    = y_reg[9:3];

    always_comb begin
        nb_x = tile_x;
        nb_y = tile_y;
        case (probe_dir)
            RIGHT: nb_x = tile_x + 7'd1;
            LEFT:  nb_x = tile_x - 7'd1;
            UP:    nb_y = tile_y - 7'd1;
            DOWN:  nb_y = tile_y + 7'd1;
        endcase
    end

    // Stepping off column 0 or row 0 wraps to 127, which the range test rejects.
    assign nb_in_range = (nb_x < 7'(MAZE_W)) && (nb_y < 7'(MAZE_H));

    maze_walkable u_walk (
        .tile_col (nb_x[4:0]),
        .tile_row (nb_y[5:0]),
        .walkable (nb_walk_raw)
    );

    assign nb_walk = nb_walk_raw & nb_in_range;

    always_comb begin
        state_next      = state_reg;
        pacman_dir_next = pacman_dir_reg;
        x_next          = x_reg;
        y_next          = y_reg;
        moving_next     = moving_reg;
        case (state_reg)
            S_WAIT: begin
                if (step_req_reg) begin
                    if (bus.freeze) begin
                        moving_next = 1'b0;
                    end else begin
                        state_next = S_DECIDE;
                    end
                end
            end
            S_DECIDE: begin
                if (desired_dir_reg == opposite(pacman_dir_reg)) begin
                    pacman_dir_next = desired_dir_reg;
                end else if (at_centre && nb_walk) begin
                    pacman_dir_next = desired_dir_reg;
                end
                state_next = S_STEP;
            end
            S_STEP: begin
                // Between centres the corridor is already known to be open.
                if (!at_centre || nb_walk) begin
                    case (pacman_dir_reg)
                        RIGHT: x_next = x_reg + 10'd1;
                        LEFT:  x_next = x_reg - 10'd1;
                        UP:    y_next = y_reg - 10'd1;
                        DOWN:  y_next = y_reg + 10'd1;
                    endcase
                    moving_next = 1'b1;
                end else begin
                    moving_next = 1'b0;
                end
                state_next = S_WAIT;
            end
            default: state_next = S_WAIT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg      <= S_WAIT;
            pacman_dir_reg <= LEFT;
            x_reg          <= X_START;
            y_reg          <= Y_START;
            moving_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pacman_dir_reg <= pacman_dir_next;
            x_reg          <= x_next;
            y_reg          <= y_next;
            moving_reg     <= moving_next;
        end
    end

    assign bus.pacman_X   = x_reg;
    assign bus.pacman_Y   = y_reg;
    assign bus.pacman_dir = pacman_dir_reg;
    assign bus.moving     = moving_reg;

endmodule

// File: tb/tb_pacman_motion.sv
// Bench for pacman_motion: directed vector table, hand-built timing/reset sequences,
// and random key/freeze traffic checked against a tile-grid reference model.
module tb_pacman_motion;

    logic Clk = 1'b0;
    logic Reset;
    logic Reset3;

    always #5 Clk = ~Clk;

    pacman_motion_if bus ();
    pacman_motion_if bus3 ();

    pacman_motion #(.START_TILE_X(13), .START_TILE_Y(29), .TICKS_PER_STEP(1)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    pacman_motion #(.START_TILE_X(13), .START_TILE_Y(29), .TICKS_PER_STEP(3)) dut3 (
        .Clk   (Clk),
        .Reset (Reset3),
        .bus   (bus3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Maze as drawn: '.' corridor, '#' wall.
    string maze [36];
    int dx  [4] = '{1, -1, 0, 0};
    int dy  [4] = '{0, 0, -1, 1};
    int opp [4] = '{1, 0, 3, 2};

    int m_x, m_y, m_dir, m_des, m_mov;

    typedef struct packed {
        logic       rst;
        logic [7:0] key;
        logic       frz;
        int         ticks;
        int         x;
        int         y;
        int         dir;
        int         mov;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic bit walk(input int c, input int r);
        if (c < 0 || c > 27 || r < 0 || r > 35) return 1'b0;
        return maze[r].getc(c) == ".";
    endfunction

    task automatic model_reset();
        m_x = 108; m_y = 236; m_dir = 1; m_des = 1; m_mov = 0;
    endtask

    task automatic model_key(input logic [7:0] k);
        case (k)
            8'h1A: m_des = 2;
            8'h04: m_des = 1;
            8'h16: m_des = 3;
            8'h07: m_des = 0;
            default: ;
        endcase
    endtask

    task automatic model_tick(input bit frz);
        int  tc, tr;
        bit  centre;
        if (frz) begin
            m_mov = 0;
            return;
        end
        tc = m_x / 8;
        tr = m_y / 8;
        centre = (m_x % 8 == 4) && (m_y % 8 == 4);
        if (m_des == opp[m_dir]) m_dir = m_des;
        else if (centre && walk(tc + dx[m_des], tr + dy[m_des])) m_dir = m_des;
        if (!centre || walk(tc + dx[m_dir], tr + dy[m_dir])) begin
            m_x = m_x + dx[m_dir];
            m_y = m_y + dy[m_dir];
            m_mov = 1;
        end else begin
            m_mov = 0;
        end
    endtask

    task automatic do_reset();
        @(posedge Clk); #1;
        Reset = 1'b1; bus.frame_clk = 1'b0; bus.keycode = 8'h00;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        model_reset();
    endtask

    task automatic press(input logic [7:0] k);
        @(posedge Clk); #1 bus.keycode = k;
        @(posedge Clk); #1 bus.keycode = 8'h00;
        model_key(k);
    endtask

    task automatic tick();
        @(posedge Clk); #1 bus.frame_clk = 1'b1;
        repeat (6) @(posedge Clk);
        #1 bus.frame_clk = 1'b0;
        repeat (2) @(posedge Clk);
        model_tick(bus.freeze);
    endtask

    task automatic reset3();
        @(posedge Clk); #1;
        Reset3 = 1'b1; bus3.frame_clk = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Reset3 = 1'b0;
    endtask

    task automatic tick3();
        @(posedge Clk); #1 bus3.frame_clk = 1'b1;
        repeat (6) @(posedge Clk);
        #1 bus3.frame_clk = 1'b0;
        repeat (2) @(posedge Clk);
    endtask

    task automatic check_model(input string tag);
        @(negedge Clk);
        chk({tag, "_x"},   int'(bus.pacman_X),   m_x);
        chk({tag, "_y"},   int'(bus.pacman_Y),   m_y);
        chk({tag, "_dir"}, int'(bus.pacman_dir), m_dir);
        chk({tag, "_mov"}, int'(bus.moving),     m_mov);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] rkeys [6];
        rkeys = '{8'h1A, 8'h04, 8'h16, 8'h07, 8'h05, 8'h2C};

        maze[0]  = "############################";
        maze[1]  = "#............##............#";
        maze[2]  = "#.####.#####.##.#####.####.#";
        maze[3]  = "#.####.#####.##.#####.####.#";
        maze[4]  = "#.####.#####.##.#####.####.#";
        maze[5]  = "#..........................#";
        maze[6]  = "#.####.##.########.##.####.#";
        maze[7]  = "#.####.##.########.##.####.#";
        maze[8]  = "#......##....##....##......#";
        maze[9]  = "######.#####.##.#####.######";
        maze[10] = "######.#####.##.#####.######";
        maze[11] = "######.##..........##.######";
        maze[12] = "######.##.########.##.######";
        maze[13] = "######.##.########.##.######";
        maze[14] = "..........########..........";
        maze[15] = "######.##.########.##.######";
        maze[16] = "######.##.########.##.######";
        maze[17] = "######.##..........##.######";
        maze[18] = "######.##.########.##.######";
        maze[19] = "######.##.########.##.######";
        maze[20] = "#............##............#";
        maze[21] = "#.####.#####.##.#####.####.#";
        maze[22] = "#.####.#####.##.#####.####.#";
        maze[23] = "#...##................##...#";
        maze[24] = "###.##.##.########.##.##.###";
        maze[25] = "###.##.##.########.##.##.###";
        maze[26] = "#......##....##....##......#";
        maze[27] = "#.##########.##.##########.#";
        maze[28] = "#.##########.##.##########.#";
        maze[29] = "#..........................#";
        for (int r = 30; r < 36; r++) maze[r] = maze[0];
        for (int r = 0; r < 36; r++) begin
            if (maze[r].len() != 28) begin
                $display("FAIL maze_row%0d: length %0d, expected 28", r, maze[r].len());
                $fatal(1);
            end
        end

        //            rst  key    frz ticks  x    y    dir mov
        vecs = '{
            '{1'b1, 8'h00, 1'b0,  0, 108, 236, 1, 0},
            '{1'b0, 8'h00, 1'b0,  5, 103, 236, 1, 1},
            '{1'b1, 8'h07, 1'b0,  1, 109, 236, 0, 1},
            '{1'b1, 8'h1A, 1'b0,  1, 107, 236, 1, 1},
            '{1'b0, 8'h00, 1'b0,  7, 100, 236, 1, 1},
            '{1'b0, 8'h00, 1'b0,  1, 100, 235, 2, 1},
            '{1'b1, 8'h00, 1'b0, 96,  12, 236, 1, 1},
            '{1'b0, 8'h00, 1'b0,  3,  12, 236, 1, 0},
            '{1'b1, 8'h00, 1'b0,  3, 105, 236, 1, 1},
            '{1'b0, 8'h1A, 1'b1, 10, 105, 236, 1, 0},
            '{1'b0, 8'h00, 1'b0,  5, 100, 236, 1, 1},
            '{1'b0, 8'h00, 1'b0,  1, 100, 235, 2, 1},
            '{1'b0, 8'h00, 1'b0, 23, 100, 212, 2, 1},
            '{1'b0, 8'h00, 1'b0,  1, 100, 212, 2, 0},
            '{1'b0, 8'h16, 1'b0,  1, 100, 213, 3, 1}
        };

        Reset = 1'b1; Reset3 = 1'b1;
        bus.frame_clk = 1'b0;  bus.keycode = 8'h00;  bus.freeze = 1'b0;
        bus3.frame_clk = 1'b0; bus3.keycode = 8'h00; bus3.freeze = 1'b0;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0; Reset3 = 1'b0;
        model_reset();

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].rst) do_reset();
            bus.freeze = vecs[i].frz;
            if (vecs[i].key != 8'h00) press(vecs[i].key);
            repeat (vecs[i].ticks) tick();
            @(negedge Clk);
            chk($sformatf("vec%0d_x", i),   int'(bus.pacman_X),   vecs[i].x);
            chk($sformatf("vec%0d_y", i),   int'(bus.pacman_Y),   vecs[i].y);
            chk($sformatf("vec%0d_dir", i), int'(bus.pacman_dir), vecs[i].dir);
            chk($sformatf("vec%0d_mov", i), int'(bus.moving),     vecs[i].mov);
            $display("vec%0d: X=%0d Y=%0d dir=%0d moving=%0d", i,
                     bus.pacman_X, bus.pacman_Y, bus.pacman_dir, bus.moving);
        end
        bus.freeze = 1'b0;

        // Position moves on the third edge after the one that sees frame_clk rise.
        do_reset();
        @(posedge Clk); #1 bus.frame_clk = 1'b1;
        @(posedge Clk);
        @(negedge Clk); chk("lat_e0_x", int'(bus.pacman_X), 108);
        @(negedge Clk); chk("lat_e1_x", int'(bus.pacman_X), 108);
        @(negedge Clk); chk("lat_e2_x", int'(bus.pacman_X), 108);
        @(negedge Clk); chk("lat_e3_x", int'(bus.pacman_X), 107);
        bus.frame_clk = 1'b0;
        repeat (2) @(posedge Clk);
        $display("latency: X=%0d after three edges", bus.pacman_X);

        // Reset landing in the middle of a step discards that step entirely.
        do_reset();
        @(posedge Clk); #1 bus.frame_clk = 1'b1;
        @(posedge Clk);
        @(posedge Clk); #1 Reset = 1'b1; bus.frame_clk = 1'b0;
        @(posedge Clk);
        @(posedge Clk); #1 Reset = 1'b0;
        model_reset();
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        chk("midrst_x",   int'(bus.pacman_X), 108);
        chk("midrst_mov", int'(bus.moving),   0);
        tick();
        @(negedge Clk);
        chk("midrst_after_x", int'(bus.pacman_X), 107);
        $display("mid-step reset: X=%0d after one further tick", bus.pacman_X);

        // Three frame ticks per pixel.
        reset3();
        repeat (9) tick3();
        @(negedge Clk);
        chk("tps3_9t_x",   int'(bus3.pacman_X), 105);
        chk("tps3_9t_mov", int'(bus3.moving),   1);
        $display("tps3: X=%0d after 9 ticks", bus3.pacman_X);
        reset3();
        repeat (4) tick3();
        @(negedge Clk);
        chk("tps3_4t_x", int'(bus3.pacman_X), 107);
        reset3();
        @(negedge Clk);
        chk("tps3_rst_x",   int'(bus3.pacman_X), 108);
        chk("tps3_rst_y",   int'(bus3.pacman_Y), 236);
        chk("tps3_rst_mov", int'(bus3.moving),   0);
        repeat (2) tick3();
        @(negedge Clk);
        chk("tps3_2t_x", int'(bus3.pacman_X), 108);
        tick3();
        @(negedge Clk);
        chk("tps3_3t_x", int'(bus3.pacman_X), 107);
        $display("tps3 after reset: X=%0d after 3 ticks", bus3.pacman_X);

        // Random key and freeze traffic against the reference model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bus.freeze = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) press(rkeys[$urandom_range(0, 5)]);
            tick();
            check_model($sformatf("rnd%0d", i));
            $display("rnd%0d: frz=%0d X=%0d Y=%0d dir=%0d moving=%0d", i, bus.freeze,
                     bus.pacman_X, bus.pacman_Y, bus.pacman_dir, bus.moving);
        end
        bus.freeze = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
